// File: rtl/hazard_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_pkg
// Shared constants for the Tuse/Tnew hazard controller of the 5-stage MIPS
// pipeline: GRF address / timing widths, the "operand not used" Tuse code,
// the forward-mux select encoding and the Tnew values of the instruction
// classes.
// -----------------------------------------------------------------------------
package hazard_scoreboard_pkg;

    // GRF address width (32 registers, $0 hard-wired to zero)
    localparam int GRF_AW   = 5;
    // Tuse / Tnew field width
    localparam int TIMING_W = 2;

    // Tuse code meaning "this source operand is never read"
    localparam logic [1:0] TUSE_NONE = 2'b11;

    // Forward-mux selects shared by the D-stage and E-stage operand muxes
    typedef enum logic [1:0] {
        FWD_GRF = 2'd0,
        FWD_E   = 2'd1,
        FWD_M   = 2'd2,
        FWD_W   = 2'd3
    } fwd_sel_e;

    // Cycles after entering E until the result exists
    typedef enum logic [1:0] {
        TNEW_PC8  = 2'd0,
        TNEW_ALU  = 2'd1,
        TNEW_LOAD = 2'd2
    } tnew_e;

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// -----------------------------------------------------------------------------
// hazard_entry
// One pipeline-stage record of an in-flight GRF write {we, a3, tnew}.
// Instanced three times (E, M, W) by hazard_scoreboard.
//
// Ports
//   clk       in   pipeline clock
//   reset     in   synchronous active-high clear
//   bubble_i  in   load an empty record instead of the incoming one
//   we_i      in   incoming write enable
//   a3_i      in   incoming destination register
//   tnew_i    in   incoming Tnew (as held by the previous stage)
//   we_o      out  registered write enable
//   a3_o      out  registered destination register
//   tnew_o    out  registered Tnew
//
// DECREMENT selects whether Tnew counts down by one on the way in (M and W
// stages) or is taken as-is (E stage, fed straight from decode).
// -----------------------------------------------------------------------------
module hazard_entry
    import hazard_scoreboard_pkg::*;
#(
    parameter int AW        = GRF_AW,
    parameter int TW        = TIMING_W,
    parameter bit DECREMENT = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          bubble_i,
    input  logic          we_i,
    input  logic [AW-1:0] a3_i,
    input  logic [TW-1:0] tnew_i,
    output logic          we_o,
    output logic [AW-1:0] a3_o,
    output logic [TW-1:0] tnew_o
);

    logic          we_q,   we_d;
    logic [AW-1:0] a3_q,   a3_d;
    logic [TW-1:0] tnew_q, tnew_d;

    // Next record: pass-through, with a saturating count-down of Tnew when
    // this stage is downstream of E; a bubble overrides everything.
    always_comb begin
        we_d   = we_i;
        a3_d   = a3_i;
        tnew_d = tnew_i;
        if (DECREMENT && (tnew_i != '0)) begin
            tnew_d = tnew_i - TW'(1);
        end
        if (bubble_i) begin
            we_d   = 1'b0;
            a3_d   = '0;
            tnew_d = '0;
        end
    end

    // Stage register with synchronous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q   <= 1'b0;
            a3_q   <= '0;
            tnew_q <= '0;
        end else begin
            we_q   <= we_d;
            a3_q   <= a3_d;
            tnew_q <= tnew_d;
        end
    end

    assign we_o   = we_q;
    assign a3_o   = a3_q;
    assign tnew_o = tnew_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Tuse/Tnew hazard controller for the 5-stage MIPS pipeline. Tracks the GRF
// writes in flight in E/M/W, stalls the D stage when a source operand cannot
// be forwarded in time, and drives the forward-mux selects for the D-stage
// rs/rt operands and the E-stage ALU operands. All outputs are combinational
// functions of the tracked state and the current D-stage fields.
//
// Ports
//   clk        in   pipeline clock
//   reset      in   synchronous active-high; clears every tracked entry
//   d_rs       in   D-stage rs field
//   d_rt       in   D-stage rt field
//   d_tuse_rs  in   cycles until D instr needs rs (0=D,1=E,2=M,3=unused)
//   d_tuse_rt  in   same for rt
//   d_we       in   D instr writes the GRF
//   d_a3       in   D instr destination register
//   d_tnew     in   cycles after entering E until the result is ready
//   stall      out  freeze PC/F/D and insert a bubble into E
//   fwd_d_rs   out  D rs mux: 0 GRF, 1 E, 2 M, 3 W
//   fwd_d_rt   out  D rt mux, same encoding
//   fwd_e_rs   out  E rs mux: 0 carried value, 2 M, 3 W
//   fwd_e_rt   out  E rt mux, same encoding
// -----------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int AW = GRF_AW,
    parameter int TW = TIMING_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] d_rs,
    input  logic [AW-1:0] d_rt,
    input  logic [TW-1:0] d_tuse_rs,
    input  logic [TW-1:0] d_tuse_rt,
    input  logic          d_we,
    input  logic [AW-1:0] d_a3,
    input  logic [TW-1:0] d_tnew,
    output logic          stall,
    output logic [1:0]    fwd_d_rs,
    output logic [1:0]    fwd_d_rt,
    output logic [1:0]    fwd_e_rs,
    output logic [1:0]    fwd_e_rt
);

    // -------------------------------------------------------------------------
    // Tracked stage records
    // -------------------------------------------------------------------------
    logic          eWe,   mWe,   wWe;
    logic [AW-1:0] eA3,   mA3,   wA3;
    logic [TW-1:0] eTnew, mTnew, wTnew;

    // Source registers of the instruction sitting in E, for E-stage forwarding
    logic [AW-1:0] eRs_q, eRs_d;
    logic [AW-1:0] eRt_q, eRt_d;

    // E takes the decoded instruction straight from D, or a bubble on stall
    hazard_entry #(.AW(AW), .TW(TW), .DECREMENT(1'b0)) uEntryE (
        .clk      (clk),
        .reset    (reset),
        .bubble_i (stall),
        .we_i     (d_we),
        .a3_i     (d_a3),
        .tnew_i   (d_tnew),
        .we_o     (eWe),
        .a3_o     (eA3),
        .tnew_o   (eTnew)
    );

    // M receives E one cycle older, so its Tnew is one less
    hazard_entry #(.AW(AW), .TW(TW), .DECREMENT(1'b1)) uEntryM (
        .clk      (clk),
        .reset    (reset),
        .bubble_i (1'b0),
        .we_i     (eWe),
        .a3_i     (eA3),
        .tnew_i   (eTnew),
        .we_o     (mWe),
        .a3_o     (mA3),
        .tnew_o   (mTnew)
    );

    // W also counts down; the longest producer (load) reaches zero here, so
    // every W record is ready by construction
    hazard_entry #(.AW(AW), .TW(TW), .DECREMENT(1'b1)) uEntryW (
        .clk      (clk),
        .reset    (reset),
        .bubble_i (1'b0),
        .we_i     (mWe),
        .a3_i     (mA3),
        .tnew_i   (mTnew),
        .we_o     (wWe),
        .a3_o     (wA3),
        .tnew_o   (wTnew)
    );

    // E-stage source fields follow the same bubble rule as the E record
    always_comb begin
        eRs_d = d_rs;
        eRt_d = d_rt;
        if (stall) begin
            eRs_d = '0;
            eRt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            eRs_q <= '0;
            eRt_q <= '0;
        end else begin
            eRs_q <= eRs_d;
            eRt_q <= eRt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Match / priority helpers
    // -------------------------------------------------------------------------

    // A record supplies register r only if it writes, targets r, and r is not
    // the hard-wired $0
    function automatic logic hits(input logic we, input logic [AW-1:0] a3,
                                  input logic [AW-1:0] r);
        return we && (a3 == r) && (r != '0);
    endfunction

    // Only the youngest matching producer in E/M decides; W is always ready
    function automatic logic needStall(input logic hitE, input logic hitM,
                                       input logic [TW-1:0] tE,
                                       input logic [TW-1:0] tM,
                                       input logic [TW-1:0] tuse);
        if (tuse == TW'(TUSE_NONE)) return 1'b0;
        if (hitE)                   return tE > tuse;
        if (hitM)                   return tM > tuse;
        return 1'b0;
    endfunction

    // The youngest match wins even when it is not ready yet; an older ready
    // copy would carry a stale value
    function automatic logic [1:0] pickFwdD(input logic hitE, input logic hitM,
                                            input logic hitW,
                                            input logic [TW-1:0] tE,
                                            input logic [TW-1:0] tM,
                                            input logic [TW-1:0] tW);
        if (hitE) return (tE == '0) ? FWD_E : FWD_GRF;
        if (hitM) return (tM == '0) ? FWD_M : FWD_GRF;
        if (hitW) return (tW == '0) ? FWD_W : FWD_GRF;
        return FWD_GRF;
    endfunction

    function automatic logic [1:0] pickFwdE(input logic hitM, input logic hitW);
        if (hitM) return FWD_M;
        if (hitW) return FWD_W;
        return FWD_GRF;
    endfunction

    // -------------------------------------------------------------------------
    // Per-operand match vectors
    // -------------------------------------------------------------------------
    logic hitErs, hitMrs, hitWrs;
    logic hitErt, hitMrt, hitWrt;
    logic hitMeRs, hitWeRs, hitMeRt, hitWeRt;

    assign hitErs  = hits(eWe, eA3, d_rs);
    assign hitMrs  = hits(mWe, mA3, d_rs);
    assign hitWrs  = hits(wWe, wA3, d_rs);
    assign hitErt  = hits(eWe, eA3, d_rt);
    assign hitMrt  = hits(mWe, mA3, d_rt);
    assign hitWrt  = hits(wWe, wA3, d_rt);
    assign hitMeRs = hits(mWe, mA3, eRs_q);
    assign hitWeRs = hits(wWe, wA3, eRs_q);
    assign hitMeRt = hits(mWe, mA3, eRt_q);
    assign hitWeRt = hits(wWe, wA3, eRt_q);

    // -------------------------------------------------------------------------
    // Outputs: rs and rt evaluated independently, so rs==rt gives equal selects
    // -------------------------------------------------------------------------
    assign stall = needStall(hitErs, hitMrs, eTnew, mTnew, d_tuse_rs)
                 | needStall(hitErt, hitMrt, eTnew, mTnew, d_tuse_rt);

    assign fwd_d_rs = pickFwdD(hitErs, hitMrs, hitWrs, eTnew, mTnew, wTnew);
    assign fwd_d_rt = pickFwdD(hitErt, hitMrt, hitWrt, eTnew, mTnew, wTnew);

    assign fwd_e_rs = pickFwdE(hitMeRs, hitWeRs);
    assign fwd_e_rt = pickFwdE(hitMeRt, hitWeRt);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
// Self-checking bench for hazard_scoreboard. Each scenario task drives one
// D-stage instruction per cycle, pushes the expected
// {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt} for that cycle into a
// queue, and pops/compares it on the falling edge. Expected values are
// derived by hand from the pipeline timing of each instruction sequence.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    logic       clk;
    logic       reset;
    logic [4:0] d_rs, d_rt, d_a3;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_we;
    logic       stall;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

    int total = 0;
    int bad   = 0;

    logic [8:0] expQ[$];
    logic [8:0] got, want;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] urs;
        logic [1:0] urt;
        logic       we;
        logic [4:0] a3;
        logic [1:0] tnew;
    } instr_t;

    hazard_scoreboard dut (
        .clk       (clk),
        .reset     (reset),
        .d_rs      (d_rs),
        .d_rt      (d_rt),
        .d_tuse_rs (d_tuse_rs),
        .d_tuse_rt (d_tuse_rt),
        .d_we      (d_we),
        .d_a3      (d_a3),
        .d_tnew    (d_tnew),
        .stall     (stall),
        .fwd_d_rs  (fwd_d_rs),
        .fwd_d_rt  (fwd_d_rt),
        .fwd_e_rs  (fwd_e_rs),
        .fwd_e_rt  (fwd_e_rt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time bound so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run did not finish, required finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    // -------------------------------------------------------------------------
    // Instruction builders
    // -------------------------------------------------------------------------
    function automatic instr_t mk(input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [1:0] urs, input logic [1:0] urt,
                                  input logic we, input logic [4:0] a3,
                                  input logic [1:0] tnew);
        instr_t x;
        x.rs = rs; x.rt = rt; x.urs = urs; x.urt = urt;
        x.we = we; x.a3 = a3; x.tnew = tnew;
        return x;
    endfunction

    function automatic instr_t iNop();
        return mk(5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0);
    endfunction
    function automatic instr_t iLw(input logic [4:0] d);
        return mk(5'd0, 5'd0, 2'd1, 2'd3, 1'b1, d, TNEW_LOAD);
    endfunction
    function automatic instr_t iAddu(input logic [4:0] d, input logic [4:0] s,
                                     input logic [4:0] t);
        return mk(s, t, 2'd1, 2'd1, 1'b1, d, TNEW_ALU);
    endfunction
    function automatic instr_t iBeq(input logic [4:0] s, input logic [4:0] t);
        return mk(s, t, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0);
    endfunction
    function automatic instr_t iJal();
        return mk(5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd31, TNEW_PC8);
    endfunction
    function automatic instr_t iJr(input logic [4:0] s);
        return mk(s, 5'd0, 2'd0, 2'd3, 1'b0, 5'd0, 2'd0);
    endfunction
    function automatic instr_t iSw(input logic [4:0] s, input logic [4:0] t);
        return mk(s, t, 2'd1, 2'd2, 1'b0, 5'd0, 2'd0);
    endfunction

    function automatic logic [8:0] ex(input logic s, input logic [1:0] a,
                                      input logic [1:0] b, input logic [1:0] c,
                                      input logic [1:0] d);
        return {s, a, b, c, d};
    endfunction

    // Drive one D-stage instruction onto the DUT inputs
    task automatic applyStimulus(input instr_t x);
        d_rs = x.rs; d_rt = x.rt; d_tuse_rs = x.urs; d_tuse_rt = x.urt;
        d_we = x.we; d_a3 = x.a3; d_tnew = x.tnew;
    endtask

    // Clear the tracked state, leaving a nop in D at posedge+1
    task automatic doReset();
        reset = 1'b1;
        applyStimulus(iNop());
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Scenarios
    // -------------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        applyStimulus(iBeq(5'd8, 5'd8));
        @(posedge clk); #1;
        expQ.push_back(ex(0, 0, 0, 0, 0));
        @(negedge clk);
        got  = {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt};
        want = expQ.pop_front();
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL reset_held: got %b required %b", got, want);
        end
        reset = 1'b0;
        expQ.push_back(ex(0, 0, 0, 0, 0));
        @(negedge clk);
        got  = {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt};
        want = expQ.pop_front();
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL reset_released: got %b required %b", got, want);
        end
        @(posedge clk); #1;
    endtask

    // lw $8 ; addu $10,$8,$9 : one stall, then W forward into E
    task automatic test_load_use();
        instr_t prog[$];
        logic [8:0] ev[$];
        doReset();
        prog.push_back(iLw(5'd8));               ev.push_back(ex(0, 0, 0, 0, 0));
        prog.push_back(iAddu(5'd10, 5'd8, 5'd9)); ev.push_back(ex(1, 0, 0, 0, 0));
        prog.push_back(iAddu(5'd10, 5'd8, 5'd9)); ev.push_back(ex(0, 0, 0, 0, 0));
        prog.push_back(iNop());                  ev.push_back(ex(0, 0, 0, 3, 0));
        for (int i = 0; i < prog.size(); i++) begin
            applyStimulus(prog[i]);
            expQ.push_back(ev[i]);
            @(negedge clk);
            got  = {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt};
            want = expQ.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("[TB] FAIL load_use c%0d: got %b required %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    // lw $8 ; beq $8,$0 : two stalls with bubbles, then W forward into D
    task automatic test_load_branch();
        instr_t prog[$];
        logic [8:0] ev[$];
        doReset();
        prog.push_back(iLw(5'd8));         ev.push_back(ex(0, 0, 0, 0, 0));
        prog.push_back(iBeq(5'd8, 5'd0));  ev.push_back(ex(1, 0, 0, 0, 0));
        prog.push_back(iBeq(5'd8, 5'd0));  ev.push_back(ex(1, 0, 0, 0, 0));
        prog.push_back(iBeq(5'd8, 5'd0));  ev.push_back(ex(0, 3, 0, 0, 0));
        prog.push_back(iNop());            ev.push_back(ex(0, 0, 0, 0, 0));
        for (int i = 0; i < prog.size(); i++) begin
            applyStimulus(prog[i]);
            expQ.push_back(ev[i]);
            @(negedge clk);
            got  = {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt};
            want = expQ.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("[TB] FAIL load_branch c%0d: got %b required %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    // addu $9 ; beq $9,$9 : one stall, equal selects on rs and rt
    task automatic test_alu_branch();
        instr_t prog[$];
        logic [8:0] ev[$];
        doReset();
        prog.push_back(iAddu(5'd9, 5'd1, 5'd2)); ev.push_back(ex(0, 0, 0, 0, 0));
        prog.push_back(iBeq(5'd9, 5'd9));        ev.push_back(ex(1, 0, 0, 0, 0));
        prog.push_back(iBeq(5'd9, 5'd9));        ev.push_back(ex(0, 2, 2, 0, 0));
        prog.push_back(iNop());                  ev.push_back(ex(0, 0, 0, 3, 3));
        for (int i = 0; i < prog.size(); i++) begin
            applyStimulus(prog[i]);
            expQ.push_back(ev[i]);
            @(negedge clk);
            got  = {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt};
            want = expQ.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("[TB] FAIL alu_branch c%0d: got %b required %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    // jal ; jr $31 : forward from E without stall, then from M (Tnew held at 0)
    task automatic test_jal_jr();
        instr_t prog[$];
        logic [8:0] ev[$];
        doReset();
        prog.push_back(iJal());      ev.push_back(ex(0, 0, 0, 0, 0));
        prog.push_back(iJr(5'd31));  ev.push_back(ex(0, 1, 0, 0, 0));
        prog.push_back(iNop());      ev.push_back(ex(0, 0, 0, 2, 0));
        for (int i = 0; i < prog.size(); i++) begin
            applyStimulus(prog[i]);
            expQ.push_back(ev[i]);
            @(negedge clk);
            got  = {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt};
            want = expQ.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("[TB] FAIL jal_jr c%0d: got %b required %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    // Writes to $0 never stall and never forward
    task automatic test_zero_reg();
        instr_t prog[$];
        logic [8:0] ev[$];
        doReset();
        prog.push_back(iLw(5'd0));               ev.push_back(ex(0, 0, 0, 0, 0));
        prog.push_back(iAddu(5'd0, 5'd0, 5'd0)); ev.push_back(ex(0, 0, 0, 0, 0));
        prog.push_back(iBeq(5'd0, 5'd0));        ev.push_back(ex(0, 0, 0, 0, 0));
        prog.push_back(iBeq(5'd0, 5'd0));        ev.push_back(ex(0, 0, 0, 0, 0));
        prog.push_back(iNop());                  ev.push_back(ex(0, 0, 0, 0, 0));
        for (int i = 0; i < prog.size(); i++) begin
            applyStimulus(prog[i]);
            expQ.push_back(ev[i]);
            @(negedge clk);
            got  = {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt};
            want = expQ.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("[TB] FAIL zero_reg c%0d: got %b required %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    // lw $5 ; addu $5 ; addu $6,$5 : youngest (E, Tnew 1) decides, then M into E
    task automatic test_youngest();
        instr_t prog[$];
        logic [8:0] ev[$];
        doReset();
        prog.push_back(iLw(5'd5));               ev.push_back(ex(0, 0, 0, 0, 0));
        prog.push_back(iAddu(5'd5, 5'd1, 5'd2)); ev.push_back(ex(0, 0, 0, 0, 0));
        prog.push_back(iAddu(5'd6, 5'd5, 5'd0)); ev.push_back(ex(0, 0, 0, 0, 0));
        prog.push_back(iNop());                  ev.push_back(ex(0, 0, 0, 2, 0));
        for (int i = 0; i < prog.size(); i++) begin
            applyStimulus(prog[i]);
            expQ.push_back(ev[i]);
            @(negedge clk);
            got  = {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt};
            want = expQ.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("[TB] FAIL youngest c%0d: got %b required %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    // addu $4 ; lw $4 ; sw $4 : ready M copy must be shadowed by the younger load
    task automatic test_ready_shadow();
        instr_t prog[$];
        logic [8:0] ev[$];
        doReset();
        prog.push_back(iAddu(5'd4, 5'd1, 5'd2)); ev.push_back(ex(0, 0, 0, 0, 0));
        prog.push_back(iLw(5'd4));               ev.push_back(ex(0, 0, 0, 0, 0));
        prog.push_back(iSw(5'd0, 5'd4));         ev.push_back(ex(0, 0, 0, 0, 0));
        for (int i = 0; i < prog.size(); i++) begin
            applyStimulus(prog[i]);
            expQ.push_back(ev[i]);
            @(negedge clk);
            got  = {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt};
            want = expQ.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("[TB] FAIL ready_shadow c%0d: got %b required %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    // lw $3 ; addu $1,$2,$3 : hazard on the rt operand only
    task automatic test_rt_stall();
        instr_t prog[$];
        logic [8:0] ev[$];
        doReset();
        prog.push_back(iLw(5'd3));               ev.push_back(ex(0, 0, 0, 0, 0));
        prog.push_back(iAddu(5'd1, 5'd2, 5'd3)); ev.push_back(ex(1, 0, 0, 0, 0));
        prog.push_back(iAddu(5'd1, 5'd2, 5'd3)); ev.push_back(ex(0, 0, 0, 0, 0));
        prog.push_back(iNop());                  ev.push_back(ex(0, 0, 0, 0, 3));
        for (int i = 0; i < prog.size(); i++) begin
            applyStimulus(prog[i]);
            expQ.push_back(ev[i]);
            @(negedge clk);
            got  = {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt};
            want = expQ.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("[TB] FAIL rt_stall c%0d: got %b required %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    // lw $7 ; beq $7 stalls, reset asserted on the stalled cycle clears it
    task automatic test_reset_mid_stall();
        instr_t prog[$];
        logic [8:0] ev[$];
        doReset();
        prog.push_back(iLw(5'd7));         ev.push_back(ex(0, 0, 0, 0, 0));
        prog.push_back(iBeq(5'd7, 5'd0));  ev.push_back(ex(1, 0, 0, 0, 0));
        prog.push_back(iBeq(5'd7, 5'd0));  ev.push_back(ex(0, 0, 0, 0, 0));
        prog.push_back(iNop());            ev.push_back(ex(0, 0, 0, 0, 0));
        for (int i = 0; i < prog.size(); i++) begin
            applyStimulus(prog[i]);
            expQ.push_back(ev[i]);
            @(negedge clk);
            got  = {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt};
            want = expQ.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("[TB] FAIL reset_mid_stall c%0d: got %b required %b", i, got, want);
            end
            if (i == 1) reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(iNop());
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_load_branch();
        test_alu_branch();
        test_jal_jr();
        test_zero_reg();
        test_youngest();
        test_ready_shadow();
        test_rt_stall();
        test_reset_mid_stall();
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d leftover required 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
